// File: rtl/cgra_config_sequencer_if.sv
// Host command, config-entry and array-side bus for cgra_config_sequencer.
// master: host/test side; slave: the sequencer.
interface cgra_config_sequencer_if #(
    parameter int PE_ROW_BIT_LENGTH       = 2,
    parameter int PE_COLUMN_BIT_LENGTH    = 2,
    parameter int INPUT_NUM_BIT_LENGTH    = 3,
    parameter int OPERATION_BIT_LENGTH    = 4,
    parameter int CONTEXT_SIZE_BIT_LENGTH = 3,
    parameter int DATA_WIDTH              = 32,
    parameter int ENTRY_CNT_WIDTH         = 8,
    parameter int RUN_CNT_WIDTH           = 16
) ();
    logic                               cmd_start;
    logic [ENTRY_CNT_WIDTH-1:0]         cmd_num_entries;
    logic [CONTEXT_SIZE_BIT_LENGTH-1:0] cmd_context_max;
    logic [RUN_CNT_WIDTH-1:0]           cmd_run_cycles;
    logic                               abort;

    logic                               in_valid;
    logic                               in_ready;
    logic [PE_ROW_BIT_LENGTH-1:0]       in_row;
    logic [PE_COLUMN_BIT_LENGTH-1:0]    in_col;
    logic [INPUT_NUM_BIT_LENGTH-1:0]    in_sel1;
    logic [INPUT_NUM_BIT_LENGTH-1:0]    in_sel2;
    logic [OPERATION_BIT_LENGTH-1:0]    in_op;
    logic [DATA_WIDTH-1:0]              in_const;
    logic [CONTEXT_SIZE_BIT_LENGTH-1:0] in_ctx;

    logic [PE_ROW_BIT_LENGTH-1:0]       cfg_row;
    logic [PE_COLUMN_BIT_LENGTH-1:0]    cfg_col;
    logic [INPUT_NUM_BIT_LENGTH-1:0]    cfg_sel1;
    logic [INPUT_NUM_BIT_LENGTH-1:0]    cfg_sel2;
    logic [OPERATION_BIT_LENGTH-1:0]    cfg_op;
    logic [DATA_WIDTH-1:0]              cfg_const;
    logic [CONTEXT_SIZE_BIT_LENGTH-1:0] cfg_ctx;
    logic                               cfg_write;

    logic                               start_exec;
    logic [CONTEXT_SIZE_BIT_LENGTH-1:0] mapping_context_max_id;
    logic                               busy;
    logic                               done;
    logic                               err;

    modport master (
        output cmd_start, cmd_num_entries, cmd_context_max,
        output cmd_run_cycles, abort,
        output in_valid, in_row, in_col, in_sel1, in_sel2,
        output in_op, in_const, in_ctx,
        input  in_ready,
        input  cfg_row, cfg_col, cfg_sel1, cfg_sel2,
        input  cfg_op, cfg_const, cfg_ctx, cfg_write,
        input  start_exec, mapping_context_max_id,
        input  busy, done, err
    );

    modport slave (
        input  cmd_start, cmd_num_entries, cmd_context_max,
        input  cmd_run_cycles, abort,
        input  in_valid, in_row, in_col, in_sel1, in_sel2,
        input  in_op, in_const, in_ctx,
        output in_ready,
        output cfg_row, cfg_col, cfg_sel1, cfg_sel2,
        output cfg_op, cfg_const, cfg_ctx, cfg_write,
        output start_exec, mapping_context_max_id,
        output busy, done, err
    );
endinterface

// File: rtl/cgra_config_sequencer.sv
// CGRA config loader: streams N entries onto the config bus, starts the array, times the run.
// Optional CFG_SEQ_RANGE_CHECK_EN drops out-of-range entries and raises a sticky err.
module cgra_config_sequencer #(
    parameter int PE_ROW_SIZE             = 4,
    parameter int PE_COLUMN_SIZE          = 4,
    parameter int PE_ROW_BIT_LENGTH       = 2,
    parameter int PE_COLUMN_BIT_LENGTH    = 2,
    parameter int INPUT_NUM_BIT_LENGTH    = 3,
    parameter int OPERATION_BIT_LENGTH    = 4,
    parameter int CONTEXT_SIZE_BIT_LENGTH = 3,
    parameter int DATA_WIDTH              = 32,
    parameter int ENTRY_CNT_WIDTH         = 8,
    parameter int RUN_CNT_WIDTH           = 16
) (
    input logic                    clk,
    input logic                    reset,
    cgra_config_sequencer_if.slave bus
);
    localparam int RB  = PE_ROW_BIT_LENGTH;
    localparam int CB  = PE_COLUMN_BIT_LENGTH;
    localparam int SB  = INPUT_NUM_BIT_LENGTH;
    localparam int OB  = OPERATION_BIT_LENGTH;
    localparam int XB  = CONTEXT_SIZE_BIT_LENGTH;
    localparam int DW  = DATA_WIDTH;
    localparam int ECW = ENTRY_CNT_WIDTH;
    localparam int RCW = RUN_CNT_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_RUN,
        S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_next;

    logic [ECW-1:0] r_ent_left;
    logic [RCW-1:0] r_run_len;
    logic [RCW-1:0] r_run_left;
    logic [XB-1:0]  r_ctx_max;

    logic [RB-1:0]  r_cfg_row;
    logic [CB-1:0]  r_cfg_col;
    logic [SB-1:0]  r_cfg_sel1;
    logic [SB-1:0]  r_cfg_sel2;
    logic [OB-1:0]  r_cfg_op;
    logic [DW-1:0]  r_cfg_const;
    logic [XB-1:0]  r_cfg_ctx;
    logic           r_cfg_write;

    logic           w_in_ready;
    logic           w_start_exec;
    logic           w_done;
    logic           w_busy;
    logic           w_accept;
    logic           w_cmd;
    logic           w_drop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // abort overrides every transition and also blocks the handshake
    always_comb begin
        w_next       = r_state;
        w_in_ready   = 1'b0;
        w_start_exec = 1'b0;
        w_done       = 1'b0;
        w_busy       = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (bus.cmd_start) begin
                    if (bus.cmd_num_entries == '0) begin
                        w_next = S_START;
                    end else begin
                        w_next = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                w_in_ready = 1'b1;
                if (bus.in_valid && r_ent_left == ECW'(1)) begin
                    w_next = S_START;
                end
            end
            S_START: begin
                w_start_exec = 1'b1;
                if (r_run_len == '0) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (r_run_left == RCW'(1)) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (bus.abort) begin
            w_next     = S_IDLE;
            w_in_ready = 1'b0;
        end
    end

    assign w_accept = bus.in_valid && w_in_ready;
    assign w_cmd    = (r_state == S_IDLE) && bus.cmd_start && !bus.abort;

`ifdef CFG_SEQ_RANGE_CHECK_EN
    localparam logic [SB-1:0] L_SEL_MAX = SB'(4);

    logic r_err;

    always_comb begin
        w_drop = (32'(bus.in_row) >= PE_ROW_SIZE)
              || (32'(bus.in_col) >= PE_COLUMN_SIZE)
              || (bus.in_sel1 > L_SEL_MAX)
              || (bus.in_sel2 > L_SEL_MAX)
              || (bus.in_ctx > r_ctx_max);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_cmd) begin
            r_err <= 1'b0;
        end else if (w_accept && w_drop) begin
            r_err <= 1'b1;
        end
    end

    assign bus.err = r_err;
`else
    assign w_drop  = 1'b0;
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ent_left  <= '0;
            r_run_len   <= '0;
            r_run_left  <= '0;
            r_ctx_max   <= '0;
            r_cfg_row   <= '0;
            r_cfg_col   <= '0;
            r_cfg_sel1  <= '0;
            r_cfg_sel2  <= '0;
            r_cfg_op    <= '0;
            r_cfg_const <= '0;
            r_cfg_ctx   <= '0;
            r_cfg_write <= 1'b0;
        end else begin
            r_cfg_write <= 1'b0;
            if (w_cmd) begin
                r_ent_left <= bus.cmd_num_entries;
                r_run_len  <= bus.cmd_run_cycles;
                r_ctx_max  <= bus.cmd_context_max;
            end
            // dropped entries still count toward N
            if (w_accept) begin
                r_ent_left <= r_ent_left - ECW'(1);
                if (!w_drop) begin
                    r_cfg_row   <= bus.in_row;
                    r_cfg_col   <= bus.in_col;
                    r_cfg_sel1  <= bus.in_sel1;
                    r_cfg_sel2  <= bus.in_sel2;
                    r_cfg_op    <= bus.in_op;
                    r_cfg_const <= bus.in_const;
                    r_cfg_ctx   <= bus.in_ctx;
                    r_cfg_write <= 1'b1;
                end
            end
            if (r_state == S_START) begin
                r_run_left <= r_run_len;
            end else if (r_state == S_RUN && r_run_left != '0) begin
                r_run_left <= r_run_left - RCW'(1);
            end
        end
    end

    assign bus.in_ready               = w_in_ready;
    assign bus.cfg_row                = r_cfg_row;
    assign bus.cfg_col                = r_cfg_col;
    assign bus.cfg_sel1               = r_cfg_sel1;
    assign bus.cfg_sel2               = r_cfg_sel2;
    assign bus.cfg_op                 = r_cfg_op;
    assign bus.cfg_const              = r_cfg_const;
    assign bus.cfg_ctx                = r_cfg_ctx;
    assign bus.cfg_write              = r_cfg_write;
    assign bus.start_exec             = w_start_exec;
    assign bus.mapping_context_max_id = r_ctx_max;
    assign bus.busy                   = w_busy;
    assign bus.done                   = w_done;
endmodule

// File: tb/tb_cgra_config_sequencer.sv
// Randomized self-checking bench for cgra_config_sequencer.
// Reference model: entry list + cycle arithmetic (write=accept+1, done=start+R+1).
module tb_cgra_config_sequencer;
    localparam int PE_ROW_SIZE    = 4;
    localparam int PE_COLUMN_SIZE = 4;

`ifdef CFG_SEQ_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]  row;
        logic [1:0]  col;
        logic [2:0]  s1;
        logic [2:0]  s2;
        logic [3:0]  op;
        logic [2:0]  ctx;
        logic [31:0] cst;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cgra_config_sequencer_if bus ();

    cgra_config_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   acc_q[$];
    int   wrc_q[$];
    int   st_q[$];
    int   dn_q[$];
    ent_t wr_q[$];
    int   stable_viol = 0;
    ent_t prev_cfg;

    function automatic ent_t cfg_now();
        ent_t e;
        e.row = bus.cfg_row;
        e.col = bus.cfg_col;
        e.s1  = bus.cfg_sel1;
        e.s2  = bus.cfg_sel2;
        e.op  = bus.cfg_op;
        e.ctx = bus.cfg_ctx;
        e.cst = bus.cfg_const;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc);
            if (bus.cfg_write) begin
                wr_q.push_back(cfg_now());
                wrc_q.push_back(cyc);
            end else if (cfg_now() !== prev_cfg) begin
                stable_viol++;
            end
            if (bus.start_exec) st_q.push_back(cyc);
            if (bus.done) dn_q.push_back(cyc);
        end
        prev_cfg = cfg_now();
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic bit is_bad(ent_t e, int cm);
        return int'(e.row) >= PE_ROW_SIZE
            || int'(e.col) >= PE_COLUMN_SIZE
            || e.s1 > 3'd4 || e.s2 > 3'd4
            || int'(e.ctx) > cm;
    endfunction

    task automatic clear_mon();
        acc_q.delete();
        wrc_q.delete();
        st_q.delete();
        dn_q.delete();
        wr_q.delete();
        stable_viol = 0;
    endtask

    task automatic idle_bus();
        bus.cmd_start       = 1'b0;
        bus.cmd_num_entries = '0;
        bus.cmd_context_max = '0;
        bus.cmd_run_cycles  = '0;
        bus.abort           = 1'b0;
        bus.in_valid        = 1'b0;
        bus.in_row          = '0;
        bus.in_col          = '0;
        bus.in_sel1         = '0;
        bus.in_sel2         = '0;
        bus.in_op           = '0;
        bus.in_const        = '0;
        bus.in_ctx          = '0;
    endtask

    task automatic drive_ent(input ent_t e);
        bus.in_row   = e.row;
        bus.in_col   = e.col;
        bus.in_sel1  = e.s1;
        bus.in_sel2  = e.s2;
        bus.in_op    = e.op;
        bus.in_ctx   = e.ctx;
        bus.in_const = e.cst;
        bus.in_valid = 1'b1;
    endtask

    task automatic do_load(input int n, input int r, input int cm,
                           input int gmin, input int gmax,
                           input int bad_pct, input bit poke);
        ent_t ents[$];
        int   drv[$];
        ent_t exp_w[$];
        int   exp_wc[$];
        int   cmd_cyc;
        int   exp_st;
        int   k;
        bit   anybad;
        ent_t e;
        anybad = 1'b0;
        for (int i = 0; i < n; i++) begin
            e.row = 2'($urandom);
            e.col = 2'($urandom);
            e.s1  = ($urandom_range(0, 99) < bad_pct) ?
                    3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            e.s2  = 3'($urandom_range(0, 4));
            e.op  = 4'($urandom);
            e.cst = $urandom;
            e.ctx = ($urandom_range(0, 99) < bad_pct) ?
                    3'($urandom) : 3'($urandom_range(0, cm));
            ents.push_back(e);
        end
        @(posedge clk) #1;
        clear_mon();
        bus.cmd_num_entries = 8'(n);
        bus.cmd_run_cycles  = 16'(r);
        bus.cmd_context_max = 3'(cm);
        bus.cmd_start       = 1'b1;
        cmd_cyc = cyc;
        @(posedge clk) #1;
        bus.cmd_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(gmin, gmax)) @(posedge clk) #1;
            drive_ent(ents[i]);
            drv.push_back(cyc);
            @(negedge clk);
            k = 0;
            while (!bus.in_ready && k < 20) begin
                @(negedge clk);
                k++;
            end
            @(posedge clk) #1;
            bus.in_valid = 1'b0;
        end
        if (poke) begin
            k = 0;
            while (st_q.size() == 0 && k < 50) begin
                @(posedge clk) #1;
                k++;
            end
            repeat (2) @(posedge clk) #1;
            bus.cmd_num_entries = 8'd5;
            bus.cmd_run_cycles  = 16'd1;
            bus.cmd_context_max = ~3'(cm);
            bus.cmd_start       = 1'b1;
            @(posedge clk) #1;
            bus.cmd_start = 1'b0;
        end
        k = 0;
        @(negedge clk);
        while (!bus.done && k < r + 60) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_done busy=%0b done=%0b exp=0/0",
                     bus.busy, bus.done);
        end
        repeat (3) @(negedge clk);

        for (int i = 0; i < n; i++) begin
            if (is_bad(ents[i], cm)) anybad = 1'b1;
            if (!(RC && is_bad(ents[i], cm))) begin
                exp_w.push_back(ents[i]);
                exp_wc.push_back(drv[i] + 1);
            end
        end
        exp_st = (n == 0) ? cmd_cyc + 1 : drv[n-1] + 1;

        checks++;
        if (acc_q.size() != n) begin
            failures++;
            $display("FAIL accept_count got=%0d exp=%0d", acc_q.size(), n);
        end
        for (int i = 0; i < n && i < acc_q.size(); i++) begin
            checks++;
            if (acc_q[i] !== drv[i]) begin
                failures++;
                $display("FAIL accept_cycle[%0d] got=%0d exp=%0d",
                         i, acc_q[i], drv[i]);
            end
        end
        checks++;
        if (wr_q.size() != exp_w.size()) begin
            failures++;
            $display("FAIL write_count got=%0d exp=%0d",
                     wr_q.size(), exp_w.size());
        end
        for (int i = 0; i < exp_w.size() && i < wr_q.size(); i++) begin
            checks++;
            if (wr_q[i] !== exp_w[i]) begin
                failures++;
                $display("FAIL write_data[%0d] got=%h exp=%h",
                         i, wr_q[i], exp_w[i]);
            end
            checks++;
            if (wrc_q[i] !== exp_wc[i]) begin
                failures++;
                $display("FAIL write_cycle[%0d] got=%0d exp=%0d",
                         i, wrc_q[i], exp_wc[i]);
            end
        end
        checks++;
        if (st_q.size() != 1) begin
            failures++;
            $display("FAIL start_count got=%0d exp=1", st_q.size());
        end else if (st_q[0] !== exp_st) begin
            failures++;
            $display("FAIL start_cycle got=%0d exp=%0d", st_q[0], exp_st);
        end
        checks++;
        if (dn_q.size() != 1) begin
            failures++;
            $display("FAIL done_count got=%0d exp=1", dn_q.size());
        end else if (dn_q[0] !== exp_st + r + 1) begin
            failures++;
            $display("FAIL done_cycle got=%0d exp=%0d",
                     dn_q[0], exp_st + r + 1);
        end
        checks++;
        if (bus.err !== (RC && anybad)) begin
            failures++;
            $display("FAIL err got=%0b exp=%0b", bus.err, RC && anybad);
        end
        checks++;
        if (bus.mapping_context_max_id !== 3'(cm)) begin
            failures++;
            $display("FAIL ctx_max_id got=%0d exp=%0d",
                     bus.mapping_context_max_id, cm);
        end
        checks++;
        if (stable_viol != 0) begin
            failures++;
            $display("FAIL cfg_stable got=%0d changes exp=0", stable_viol);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_bus();
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.cfg_write, bus.start_exec, bus.busy,
             bus.done, bus.err} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=000000",
                     {bus.in_ready, bus.cfg_write, bus.start_exec,
                      bus.busy, bus.done, bus.err});
        end
        checks++;
        if (cfg_now() !== '0 || bus.mapping_context_max_id !== 3'd0) begin
            failures++;
            $display("FAIL reset_data cfg=%h id=%0d exp=0",
                     cfg_now(), bus.mapping_context_max_id);
        end
        @(posedge clk) #1;
        reset = 1'b0;
        bus.cmd_num_entries = 8'd3;
        bus.cmd_run_cycles  = 16'd4;
        bus.cmd_context_max = 3'd5;
        bus.cmd_start       = 1'b1;
        @(posedge clk) #1;
        bus.cmd_start = 1'b0;
        drive_ent(ent_t'({2'd1, 2'd2, 3'd1, 3'd2, 4'd3, 3'd1, 32'hABCD}));
        @(posedge clk) #1;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.cfg_write !== 1'b0 ||
            bus.in_ready !== 1'b0 || bus.mapping_context_max_id !== 3'd0) begin
            failures++;
            $display("FAIL reset_mid busy=%0b wr=%0b rdy=%0b id=%0d exp=0",
                     bus.busy, bus.cfg_write, bus.in_ready,
                     bus.mapping_context_max_id);
        end
        idle_bus();
        @(posedge clk) #1;
        reset = 1'b0;
        repeat (2) @(posedge clk) #1;
    endtask

    task automatic test_back_to_back();
        do_load(3, 5, 2, 0, 0, 0, 1'b0);
        do_load(6, 2, 7, 0, 0, 0, 1'b0);
    endtask

    task automatic test_gapped();
        do_load(2, 4, 1, 3, 3, 0, 1'b0);
        do_load(4, 3, 6, 0, 3, 0, 1'b0);
    endtask

    task automatic test_zero();
        do_load(0, 0, 3, 0, 0, 0, 1'b0);
        do_load(1, 0, 4, 0, 0, 0, 1'b0);
        do_load(0, 1, 2, 0, 0, 0, 1'b0);
    endtask

    task automatic test_abort();
        int k;
        @(posedge clk) #1;
        clear_mon();
        bus.cmd_num_entries = 8'd4;
        bus.cmd_run_cycles  = 16'd3;
        bus.cmd_context_max = 3'd7;
        bus.cmd_start       = 1'b1;
        @(posedge clk) #1;
        bus.cmd_start = 1'b0;
        drive_ent(ent_t'({2'd3, 2'd0, 3'd4, 3'd0, 4'd9, 3'd2, 32'h55}));
        @(posedge clk) #1;
        bus.in_valid = 1'b0;
        bus.abort    = 1'b1;
        @(posedge clk) #1;
        bus.abort = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 ||
            bus.cfg_write !== 1'b0 || bus.start_exec !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle busy=%0b rdy=%0b wr=%0b st=%0b exp=0",
                     bus.busy, bus.in_ready, bus.cfg_write, bus.start_exec);
        end
        repeat (6) @(negedge clk);
        k = st_q.size() + dn_q.size();
        checks++;
        if (k != 0 || acc_q.size() != 1) begin
            failures++;
            $display("FAIL abort_quiet events=%0d accepts=%0d exp=0/1",
                     k, acc_q.size());
        end
        @(posedge clk) #1;
        bus.abort     = 1'b1;
        bus.cmd_start = 1'b1;
        @(posedge clk) #1;
        bus.abort     = 1'b0;
        bus.cmd_start = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_beats_cmd busy=%0b exp=0", bus.busy);
        end
        do_load(1, 2, 3, 0, 0, 0, 1'b0);
    endtask

    task automatic test_cmd_in_run();
        do_load(2, 10, 3, 0, 0, 0, 1'b1);
    endtask

    task automatic test_range();
        do_load(5, 3, 2, 0, 1, 60, 1'b0);
        do_load(3, 2, 1, 0, 0, 0, 1'b0);
        do_load(4, 1, 0, 0, 2, 50, 1'b0);
    endtask

    task automatic test_max_entries();
        do_load(255, 3, 7, 0, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 20; t++) begin
            do_load($urandom_range(0, 8), $urandom_range(0, 12),
                    $urandom_range(0, 7), 0, $urandom_range(0, 3),
                    $urandom_range(0, 30), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gapped();
        test_zero();
        test_abort();
        test_cmd_in_run();
        test_range();
        test_max_entries();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
